ram_bist: RTL

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/bist_pkg.sv | 11 +
 rtl/bist_addr_gen.sv | 20 ++
 rtl/ram_bist.sv | 117 +++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding, default geometry and march element directions for ram_bist
package bist_pkg;
    localparam int AW_DEF = 6;
    localparam int DW_DEF = 8;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;
    localparam logic [3:0] ELEM_DIR = {DIR_UP, DIR_DN, DIR_UP, DIR_UP};
    typedef enum logic [3:0] {
        IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, M3_DRAIN, DONE
    } state_e;
endpackage

// File: rtl/bist_addr_gen.sv
// bist_addr_gen: up/down wrapping address counter (clk, rst_n, clr, en, dn in; addr, last out)
module bist_addr_gen
    import bist_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          dn,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic [AW-1:0] addr_q, addr_d;
    always_comb addr_d = clr ? '0 : en ? (dn ? addr_q - AW'(1) : addr_q + AW'(1)) : addr_q;
    always_ff @(posedge clk) addr_q <= !rst_n ? '0 : addr_d;
    assign addr = addr_q;
    assign last = dn ? (addr_q == '0) : (&addr_q);
endmodule

// File: rtl/ram_bist.sv
// ram_bist: march BIST controller (clk, rst_n, start, pattern, ram_q in; ram_data/addr/we, busy, done, pass, fail, fail_addr, fail_data out)
module ram_bist
    import bist_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] pattern,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data
);
    state_e        state_q, state_d;
    logic [DW-1:0] pat_q, pat_d, fail_data_q, fail_data_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d, addr, cmp_addr;
    logic          fail_q, fail_d, chk_q, chk_d, clr, en, dn, last, in_m3, cmp, mism;

    bist_addr_gen #(.AW(AW)) u_addr (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dn(dn), .addr(addr), .last(last)
    );

    assign in_m3    = state_q == M3_R || state_q == M3_DRAIN;
    assign dn       = state_q == M2_W ? ELEM_DIR[2] : state_q == M1_W ? ELEM_DIR[1] :
                      in_m3 ? ELEM_DIR[3] : ELEM_DIR[0];
    assign cmp      = state_q == M1_W || state_q == M2_W || (state_q == M3_R && chk_q) ||
                      state_q == M3_DRAIN;
    assign mism     = cmp && ram_q != (state_q == M2_W ? ~pat_q : pat_q);
    assign cmp_addr = in_m3 ? addr - AW'(1) : addr;
    assign ram_addr = addr;
    assign ram_data = state_q == M1_W ? ~pat_q : pat_q;
    assign ram_we   = state_q == M0_W || ((state_q == M1_W || state_q == M2_W) && !mism);
    assign busy      = state_q != IDLE && state_q != DONE;
    assign done      = state_q == DONE;
    assign pass      = done && !fail_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        chk_d       = 1'b0;
        clr         = 1'b0;
        en          = 1'b0;
        if (mism) begin
            state_d     = DONE;
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr;
            fail_data_d = ram_q;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_d     = M0_W;
                    clr         = 1'b1;
                    pat_d       = pattern;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
                M0_W: begin
                    en      = 1'b1;
                    state_d = last ? M1_R : M0_W;
                end
                M1_R: state_d = M1_W;
                // hold the counter at the element boundary: M2 starts where M1 ended
                M1_W: begin
                    en      = !last;
                    state_d = last ? M2_R : M1_R;
                end
                M2_R: state_d = M2_W;
                M2_W: begin
                    en      = !last;
                    state_d = last ? M3_R : M2_R;
                end
                // pipelined reads: ram_q holds the previous address once chk_q is set
                M3_R: begin
                    en      = 1'b1;
                    chk_d   = 1'b1;
                    state_d = last ? M3_DRAIN : M3_R;
                end
                M3_DRAIN: state_d = DONE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            chk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            chk_q       <= chk_d;
        end
    end
endmodule
